// File: rtl/bw_io_dq_bscan_seq.sv
// Boundary-scan DR sequencer for a DQ pad bscan chain: capture, shift, update.
// Optional BW_IO_BSCAN_SEQ_HIZ_GUARD_EN holds hiz_l low during capture/shift in extest.
module bw_io_dq_bscan_seq #(
    parameter int unsigned CHAIN_LEN = 4,
    parameter int unsigned HALF      = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req,
    input  logic                 req_mode,
    input  logic                 req_hiz_l,
    input  logic [CHAIN_LEN-1:0] req_data,
    input  logic                 bso,
    output logic                 busy,
    output logic                 done,
    output logic [CHAIN_LEN-1:0] rd_data,
    output logic                 shift_dr,
    output logic                 clock_dr,
    output logic                 update_dr,
    output logic                 mode_ctrl,
    output logic                 hiz_l,
    output logic                 bsi
);

    localparam int unsigned CW = $clog2(CHAIN_LEN + 1);
    localparam int unsigned PW = (HALF > 1) ? $clog2(2 * HALF) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CAPTURE,
        S_SHIFT,
        S_UPDATE,
        S_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [PW-1:0]          ph_q, ph_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [CHAIN_LEN-1:0]   data_q, data_d;
    logic [CHAIN_LEN-1:0]   rd_q, rd_d;
    logic                   mode_q, mode_d;
    logic                   hiz_q, hiz_d;

    logic                   last_low;
    logic                   pulse_end;
    logic                   in_pulse_state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            ph_q    <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            rd_q    <= '0;
            mode_q  <= 1'b0;
            hiz_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            ph_q    <= ph_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            rd_q    <= rd_d;
            mode_q  <= mode_d;
            hiz_q   <= hiz_d;
        end
    end

    assign last_low  = (ph_q == PW'(HALF - 1));
    assign pulse_end = (ph_q == PW'(2 * HALF - 1));

    always_comb begin
        state_d = state_q;
        ph_d    = ph_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        rd_d    = rd_q;
        mode_d  = mode_q;
        hiz_d   = hiz_q;

        unique case (state_q)
            S_IDLE: begin
                if (req) begin
                    data_d  = req_data;
                    mode_d  = req_mode;
                    hiz_d   = req_hiz_l;
                    ph_d    = '0;
                    cnt_d   = '0;
                    state_d = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                ph_d = pulse_end ? '0 : ph_q + PW'(1);
                if (pulse_end) begin
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                // bso is stable by the last low cycle, one clk before clock_dr rises
                if (last_low) begin
                    for (int unsigned k = 0; k < CHAIN_LEN; k++) begin
                        if (cnt_q == CW'(k)) begin
                            rd_d[k] = bso;
                        end
                    end
                end
                ph_d = pulse_end ? '0 : ph_q + PW'(1);
                if (pulse_end) begin
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_d == CW'(CHAIN_LEN)) begin
                        state_d = S_UPDATE;
                    end
                end
            end
            S_UPDATE: begin
                ph_d = last_low ? '0 : ph_q + PW'(1);
                if (last_low) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        in_pulse_state = (state_q == S_CAPTURE) || (state_q == S_SHIFT);
        busy      = (state_q != S_IDLE);
        done      = (state_q == S_DONE);
        shift_dr  = (state_q == S_SHIFT);
        update_dr = (state_q == S_UPDATE);
        clock_dr  = in_pulse_state && (ph_q >= PW'(HALF));
        mode_ctrl = mode_q;
        rd_data   = rd_q;
        bsi       = 1'b0;
        if (state_q == S_SHIFT) begin
            for (int unsigned k = 0; k < CHAIN_LEN; k++) begin
                if (cnt_q == CW'(k)) begin
                    bsi = data_q[k];
                end
            end
        end
`ifdef BW_IO_BSCAN_SEQ_HIZ_GUARD_EN
        hiz_l = (in_pulse_state && mode_q) ? 1'b0 : hiz_q;
`else
        hiz_l = hiz_q;
`endif
    end

endmodule
